// File: rtl/xif_sig_result_unit.sv
// Result stage of the X-interface signature coprocessor: buffers accepted
// instructions, tracks commit/kill, and executes them in order on a signature register.
module xif_sig_result_unit #(
  parameter int ID_WIDTH = 4,
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_fire_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [2:0]          issue_funct3_i,
  input  logic [4:0]          issue_rd_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [XLEN-1:0]     issue_rs2_i,
  output logic                issue_full_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o,
  output logic [XLEN-1:0]     sig_o,
  output logic                err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Result handshake: the payload is held stable while result_valid_o is high
  // and is consumed on a cycle where result_valid_o and result_ready_i are both high.

  logic [PW-1:0]       wr_ptr_q, rd_ptr_q, count;
  logic [AW-1:0]       wr_idx, rd_idx;
  logic [DEPTH-1:0]    valid_q, done_q, kill_q, commit_hit;
  logic [ID_WIDTH-1:0] id_q  [DEPTH];
  logic [2:0]          f3_q  [DEPTH];
  logic [4:0]          rd_q  [DEPTH];
  logic [XLEN-1:0]     rs1_q [DEPTH];
  logic [XLEN-1:0]     rs2_q [DEPTH];

  logic do_write, new_commit, commit_miss, slot_free;
  logic h_done, h_kill, retire_kill, retire_exec, do_pop;
  logic [2:0]      h_f3;
  logic [4:0]      h_rd;
  logic [ID_WIDTH-1:0] h_id;
  logic [XLEN-1:0] h_rs1, h_rs2;
  logic [XLEN-1:0] exec_data, sig_next, sig_q;
  logic            exec_we, exec_sig_we;

  assign wr_idx       = wr_ptr_q[AW-1:0];
  assign rd_idx       = rd_ptr_q[AW-1:0];
  assign count        = wr_ptr_q - rd_ptr_q;
  assign issue_full_o = (count == PW'(DEPTH));
  assign do_write     = issue_fire_i & ~issue_full_o;
  assign new_commit   = commit_valid_i & do_write & (commit_id_i == issue_id_i);
  assign slot_free    = ~result_valid_o | result_ready_i;
  assign sig_o        = sig_q;

  always_comb begin
    commit_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      commit_hit[i] = commit_valid_i & valid_q[i] & ~done_q[i] & (id_q[i] == commit_id_i);
    end
  end

  assign commit_miss = commit_valid_i & ~(|commit_hit) & ~new_commit;

  // Effective head sees this cycle's commit, and an empty buffer exposes the
  // incoming instruction, so a just-committed head retires without a bubble.
  always_comb begin
    h_id   = id_q[rd_idx];
    h_f3   = f3_q[rd_idx];
    h_rd   = rd_q[rd_idx];
    h_rs1  = rs1_q[rd_idx];
    h_rs2  = rs2_q[rd_idx];
    h_done = 1'b0;
    h_kill = 1'b0;
    if (valid_q[rd_idx]) begin
      h_done = done_q[rd_idx] | commit_hit[rd_idx];
      h_kill = done_q[rd_idx] ? kill_q[rd_idx] : commit_kill_i;
    end else if (do_write) begin
      h_id   = issue_id_i;
      h_f3   = issue_funct3_i;
      h_rd   = issue_rd_i;
      h_rs1  = issue_rs1_i;
      h_rs2  = issue_rs2_i;
      h_done = new_commit;
      h_kill = commit_kill_i;
    end
  end

  assign retire_kill = h_done & h_kill;
  assign retire_exec = h_done & ~h_kill & slot_free;
  assign do_pop      = retire_kill | retire_exec;

  always_comb begin
    exec_data   = '0;
    exec_we     = 1'b1;
    exec_sig_we = 1'b0;
    sig_next    = sig_q;
    case (h_f3)
      3'd0: exec_data = h_rs1 + h_rs2;
      3'd1: exec_data = h_rs1 ^ h_rs2;
      3'd2: exec_data = sig_q;
      3'd3: begin
        exec_data   = sig_q;
        sig_next    = h_rs1;
        exec_sig_we = 1'b1;
      end
      3'd4: begin
        sig_next    = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ h_rs1;
        exec_data   = sig_next;
        exec_sig_we = 1'b1;
      end
      default: exec_we = 1'b0;
    endcase
    if (h_rd == 5'd0) exec_we = 1'b0;
  end

  // Payload storage carries no reset; the valid flags qualify it.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      id_q[wr_idx]  <= issue_id_i;
      f3_q[wr_idx]  <= issue_funct3_i;
      rd_q[wr_idx]  <= issue_rd_i;
      rs1_q[wr_idx] <= issue_rs1_i;
      rs2_q[wr_idx] <= issue_rs2_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      kill_q         <= '0;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_data_o  <= '0;
      result_rd_o    <= '0;
      result_we_o    <= 1'b0;
      sig_q          <= '0;
      err_o          <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_hit[i]) begin
          done_q[i] <= 1'b1;
          kill_q[i] <= commit_kill_i;
        end
      end
      if (do_write) begin
        valid_q[wr_idx] <= 1'b1;
        done_q[wr_idx]  <= new_commit;
        kill_q[wr_idx]  <= new_commit & commit_kill_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      // Popping after the write lets a bypassed incoming head vanish cleanly.
      if (do_pop) begin
        valid_q[rd_idx] <= 1'b0;
        done_q[rd_idx]  <= 1'b0;
        kill_q[rd_idx]  <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      if (retire_exec) begin
        result_valid_o <= 1'b1;
        result_id_o    <= h_id;
        result_data_o  <= exec_data;
        result_rd_o    <= h_rd;
        result_we_o    <= exec_we;
        if (exec_sig_we) sig_q <= sig_next;
      end else if (result_ready_i) begin
        result_valid_o <= 1'b0;
      end
      if ((issue_fire_i & issue_full_o) | commit_miss) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xif_sig_result_unit.sv
// Bench for xif_sig_result_unit: directed scenarios plus random traffic checked
// against an in-order transaction model of the buffer and signature register.
module tb_xif_sig_result_unit;

  localparam int IDW = 4;
  localparam int XL  = 32;
  localparam int RW  = IDW + XL + 5 + 1;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            issue_fire_i = 1'b0;
  logic [IDW-1:0]  issue_id_i = '0;
  logic [2:0]      issue_funct3_i = '0;
  logic [4:0]      issue_rd_i = '0;
  logic [XL-1:0]   issue_rs1_i = '0;
  logic [XL-1:0]   issue_rs2_i = '0;
  logic            issue_full_o;
  logic            commit_valid_i = 1'b0;
  logic [IDW-1:0]  commit_id_i = '0;
  logic            commit_kill_i = 1'b0;
  logic            result_valid_o;
  logic            result_ready_i = 1'b0;
  logic [IDW-1:0]  result_id_o;
  logic [XL-1:0]   result_data_o;
  logic [4:0]      result_rd_o;
  logic            result_we_o;
  logic [XL-1:0]   sig_o;
  logic            err_o;

  xif_sig_result_unit #(.ID_WIDTH(IDW), .XLEN(XL), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_fire_i(issue_fire_i), .issue_id_i(issue_id_i), .issue_funct3_i(issue_funct3_i),
    .issue_rd_i(issue_rd_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_full_o(issue_full_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o), .result_rd_o(result_rd_o),
    .result_we_o(result_we_o), .sig_o(sig_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [IDW-1:0] id;
    logic [2:0]     f3;
    logic [4:0]     rd;
    logic [XL-1:0]  rs1;
    logic [XL-1:0]  rs2;
    bit             done;
    bit             kill;
  } pend_t;

  pend_t          mq[$];
  logic [RW-1:0]  exp_q[$];
  logic [XL-1:0]  m_sig;
  int             n_vec = 0;
  int             n_err = 0;

  // Transaction-level model: retire every resolved entry at the front in issue order.
  task automatic model_drain();
    pend_t         p;
    logic [XL-1:0] d;
    bit            we;
    while (mq.size() > 0 && mq[0].done) begin
      p = mq.pop_front();
      if (!p.kill) begin
        we = 1'b1;
        d  = '0;
        case (p.f3)
          3'd0: d = p.rs1 + p.rs2;
          3'd1: d = p.rs1 ^ p.rs2;
          3'd2: d = m_sig;
          3'd3: begin d = m_sig; m_sig = p.rs1; end
          3'd4: begin m_sig = ((m_sig << 1) | (m_sig >> (XL - 1))) ^ p.rs1; d = m_sig; end
          default: we = 1'b0;
        endcase
        if (p.rd == 5'd0) we = 1'b0;
        exp_q.push_back({p.id, d, p.rd, we});
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic drive_cycle(input bit fire, input bit accept, input logic [IDW-1:0] id,
                             input logic [2:0] f3, input logic [4:0] rd,
                             input logic [XL-1:0] rs1, input logic [XL-1:0] rs2,
                             input bit cv, input logic [IDW-1:0] cid, input bit ck,
                             input bit rdy);
    logic [RW-1:0] got, e;
    issue_fire_i = fire; issue_id_i = id; issue_funct3_i = f3; issue_rd_i = rd;
    issue_rs1_i = rs1; issue_rs2_i = rs2;
    commit_valid_i = cv; commit_id_i = cid; commit_kill_i = ck;
    result_ready_i = rdy;
    #1;
    if (result_valid_o && result_ready_i) begin
      got = {result_id_o, result_data_o, result_rd_o, result_we_o};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL result_unexpected: got {id,data,rd,we}=%h, expected no result", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL result_payload: got {id,data,rd,we}=%h, expected %h", got, e);
        end
      end
    end
    if (fire && accept) mq.push_back('{id, f3, rd, rs1, rs2, 1'b0, 1'b0});
    if (cv) begin
      foreach (mq[i]) begin
        if (mq[i].id == cid && !mq[i].done) begin
          mq[i].done = 1'b1;
          mq[i].kill = ck;
        end
      end
    end
    model_drain();
    @(posedge clk_i);
    @(negedge clk_i);
    issue_fire_i = 1'b0;
    commit_valid_i = 1'b0;
  endtask

  task automatic idle(input bit rdy);
    drive_cycle(0, 0, '0, '0, '0, '0, '0, 0, '0, 0, rdy);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || result_valid_o) && k < 30) begin
      idle(1);
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0 || result_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, result_valid_o=%b, expected 0 and 0",
               exp_q.size(), result_valid_o);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    issue_fire_i = 1'b0; commit_valid_i = 1'b0; result_ready_i = 1'b0;
    mq.delete(); exp_q.delete(); m_sig = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o} !== '0) begin
      n_err++;
      $display("FAIL reset_result: got %h, expected 0",
               {result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o});
    end
    n_vec++;
    if (sig_o !== '0 || err_o !== 1'b0 || issue_full_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got sig=%h err=%b full=%b, expected 0 0 0", sig_o, err_o, issue_full_o);
    end
  endtask

  task automatic test_same_cycle();
    drive_cycle(1, 1, 4'd2, 3'd0, 5'd5, 32'h10, 32'h22, 1, 4'd2, 0, 1);
    n_vec++;
    if ({result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o} !==
        {1'b1, 4'd2, 32'h32, 5'd5, 1'b1}) begin
      n_err++;
      $display("FAIL same_cycle_latency: got v=%b id=%0d data=%h rd=%0d we=%b, expected 1 2 00000032 5 1",
               result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o);
    end
    drain();
  endtask

  task automatic test_sig_ops();
    drive_cycle(1, 1, 4'd1, 3'd3, 5'd1, 32'hA5A5A5A5, 32'h0, 1, 4'd1, 0, 1);
    drive_cycle(1, 1, 4'd2, 3'd2, 5'd2, 32'h0, 32'h0, 1, 4'd2, 0, 1);
    n_vec++;
    if (result_valid_o !== 1'b1 || result_data_o !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL sig_read_back: got v=%b data=%h, expected 1 a5a5a5a5", result_valid_o, result_data_o);
    end
    drain();
    n_vec++;
    if (sig_o !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL sig_load: got %h, expected a5a5a5a5", sig_o);
    end
  endtask

  task automatic test_rotate();
    drive_cycle(1, 1, 4'd3, 3'd3, 5'd1, 32'h80000001, 32'h0, 1, 4'd3, 0, 1);
    drive_cycle(1, 1, 4'd4, 3'd4, 5'd3, 32'h1, 32'h0, 1, 4'd4, 0, 1);
    n_vec++;
    if (result_data_o !== 32'h2 || sig_o !== 32'h2) begin
      n_err++;
      $display("FAIL rotate: got data=%h sig=%h, expected 00000002 00000002", result_data_o, sig_o);
    end
    drain();
  endtask

  task automatic test_full_err();
    do_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 4'(i), 3'd0, 5'd1, 32'(i), 32'h1, 0, '0, 0, 1);
    n_vec++;
    if (issue_full_o !== 1'b1 || err_o !== 1'b0) begin
      n_err++;
      $display("FAIL full_flag: got full=%b err=%b, expected 1 0", issue_full_o, err_o);
    end
    drive_cycle(1, 0, 4'd7, 3'd0, 5'd1, 32'h5, 32'h5, 0, '0, 0, 1);
    n_vec++;
    if (err_o !== 1'b1 || issue_full_o !== 1'b1) begin
      n_err++;
      $display("FAIL issue_while_full: got err=%b full=%b, expected 1 1", err_o, issue_full_o);
    end
    drive_cycle(0, 0, '0, '0, '0, '0, '0, 1, 4'd0, 1, 1);
    n_vec++;
    if (issue_full_o !== 1'b0 || result_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL kill_head: got full=%b valid=%b, expected 0 0", issue_full_o, result_valid_o);
    end
    do_reset();
    drive_cycle(0, 0, '0, '0, '0, '0, '0, 1, 4'd9, 0, 1);
    n_vec++;
    if (err_o !== 1'b1 || result_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL unknown_commit: got err=%b valid=%b, expected 1 0", err_o, result_valid_o);
    end
  endtask

  task automatic test_out_of_order();
    logic [RW-1:0] got;
    do_reset();
    drive_cycle(1, 1, 4'd1, 3'd0, 5'd7, $urandom, $urandom, 0, '0, 0, 0);
    drive_cycle(1, 1, 4'd2, 3'd1, 5'd8, $urandom, $urandom, 0, '0, 0, 0);
    drive_cycle(1, 1, 4'd3, 3'd0, 5'd9, $urandom, $urandom, 0, '0, 0, 0);
    drive_cycle(0, 0, '0, '0, '0, '0, '0, 1, 4'd3, 0, 0);
    drive_cycle(0, 0, '0, '0, '0, '0, '0, 1, 4'd2, 0, 0);
    n_vec++;
    if (result_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL in_order_hold: got valid=%b id=%0d, expected 0", result_valid_o, result_id_o);
    end
    drive_cycle(0, 0, '0, '0, '0, '0, '0, 1, 4'd1, 0, 0);
    for (int s = 0; s < 3; s++) begin
      got = {result_id_o, result_data_o, result_rd_o, result_we_o};
      n_vec++;
      if (result_valid_o !== 1'b1 || exp_q.size() == 0 || got !== exp_q[0]) begin
        n_err++;
        $display("FAIL stall_stable[%0d]: got v=%b payload=%h, expected 1 %h", s, result_valid_o, got,
                 (exp_q.size() != 0) ? exp_q[0] : '0);
      end
      idle(0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_cycle(1, 1, 4'd4, 3'd0, 5'd2, 32'h7, 32'h8, 1, 4'd4, 0, 0);
    drive_cycle(1, 1, 4'd5, 3'd0, 5'd3, 32'h1, 32'h2, 0, '0, 0, 0);
    drive_cycle(1, 1, 4'd6, 3'd1, 5'd4, 32'h3, 32'h4, 0, '0, 0, 0);
    n_vec++;
    if (result_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_valid: got %b, expected 1", result_valid_o);
    end
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, sig_o, err_o, issue_full_o} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got v=%b id=%0d data=%h rd=%0d we=%b sig=%h err=%b full=%b, expected all 0",
               result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, sig_o, err_o, issue_full_o);
    end
    do_reset();
    drive_cycle(0, 0, '0, '0, '0, '0, '0, 1, 4'd5, 0, 1);
    for (int s = 0; s < 4; s++) begin
      n_vec++;
      if (result_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_quiet[%0d]: got valid=%b, expected 0", s, result_valid_o);
      end
      idle(1);
    end
    n_vec++;
    if (err_o !== 1'b1) begin
      n_err++;
      $display("FAIL stale_commit_err: got %b, expected 1", err_o);
    end
    drive_cycle(1, 1, 4'd6, 3'd1, 5'd4, 32'hF0F0, 32'h0FF0, 1, 4'd6, 0, 1);
    n_vec++;
    if (result_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_result: got valid=%b, expected 1", result_valid_o);
    end
    drain();
  endtask

  task automatic test_random();
    int            cand[$];
    int            k;
    bit            fire, cv;
    logic [IDW-1:0] id, cid;
    logic [4:0]    rd;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      fire = !issue_full_o && ($urandom_range(0, 2) != 0);
      id   = IDW'($urandom_range(0, 15));
      rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cand.delete();
      foreach (mq[i]) if (!mq[i].done) cand.push_back(int'(mq[i].id));
      if (fire) cand.push_back(int'(id));
      cv  = (cand.size() != 0) && ($urandom_range(0, 1) != 0);
      cid = (cand.size() != 0) ? IDW'(cand[$urandom_range(0, cand.size() - 1)]) : '0;
      drive_cycle(fire, 1, id, 3'($urandom_range(0, 7)), rd, $urandom, $urandom,
                  cv, cid, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end
    k = 0;
    while (k < 20) begin
      cand.delete();
      foreach (mq[i]) if (!mq[i].done) cand.push_back(int'(mq[i].id));
      if (cand.size() == 0) break;
      drive_cycle(0, 0, '0, '0, '0, '0, '0, 1, IDW'(cand[0]), 0, 1);
      k++;
    end
    drain();
    n_vec++;
    if (sig_o !== m_sig || err_o !== 1'b0 || issue_full_o !== 1'b0) begin
      n_err++;
      $display("FAIL random_final: got sig=%h err=%b full=%b, expected %h 0 0", sig_o, err_o, issue_full_o, m_sig);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_same_cycle();
    test_sig_ops();
    test_rotate();
    test_full_err();
    test_out_of_order();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
